// File: rtl/digit_pkg.sv
// Shared definitions for the digit display path: digit code layout,
// seven-segment glyph constants and the scanner state encoding.
package digit_pkg;

  localparam int NUM_DIGITS = 9;
  localparam int BLANK_BIT  = 4;

  // bit4 = blank request, bits3:0 = BCD value
  typedef logic [4:0] digit_t;

  // Segments a..g on bits 0..6, active-high
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to seven-segment decoder.
// Blank request turns all segments off; non-decimal BCD shows a dash.
module seg7_decode
  import digit_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_OFF;
    if (!code[BLANK_BIT]) begin
      case (code[3:0])
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// Nine-digit multiplexed seven-segment scanner.
// Snapshots all digits once per frame (LOAD), then shows each digit for
// DWELL cycles followed by GAP blank cycles, most-significant first.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros at LOAD.
module digit_scanner
  import digit_pkg::*;
#(
  parameter int DWELL = 8,
  parameter int GAP   = 2,
  parameter int IDXW  = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [4:0]      HUN_MIL,
  input  logic [4:0]      TEN_MIL,
  input  logic [4:0]      MIL,
  input  logic [4:0]      HUN_THOU,
  input  logic [4:0]      TEN_THOU,
  input  logic [4:0]      THOU,
  input  logic [4:0]      HUND,
  input  logic [4:0]      TENS,
  input  logic [4:0]      ONES,
  output logic [6:0]      SEG,
  output logic            DP,
  output logic [IDXW-1:0] IDX,
  output logic            FRAME
);

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam bit HAS_GAP = (GAP > 0);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]   GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDXW-1:0] IDX_TOP    = IDXW'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  digit_t [NUM_DIGITS-1:0] snap_q, snap_d;
  digit_t [NUM_DIGITS-1:0] raw;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       frame_q, frame_d;
  digit_t     cur_code;
  logic [6:0] dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
  logic       leading;
`endif

  // Gather inputs (index 8 = HUN_MIL) and optionally blank leading zeros
  always_comb begin
    raw[8] = HUN_MIL;
    raw[7] = TEN_MIL;
    raw[6] = MIL;
    raw[5] = HUN_THOU;
    raw[4] = TEN_THOU;
    raw[3] = THOU;
    raw[2] = HUND;
    raw[1] = TENS;
    raw[0] = ONES;
`ifdef LEADING_ZERO_BLANK_EN
    // Already-blank digits do not end the leading run; ONES is never blanked
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (!raw[i][BLANK_BIT]) begin
        if (leading && (raw[i][3:0] == 4'd0)) begin
          raw[i][BLANK_BIT] = 1'b1;
        end else begin
          leading = 1'b0;
        end
      end
    end
`endif
  end

  // Next-state, dwell counter and digit index
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_LOAD: begin
        state_d = ST_SHOW;
        cnt_d   = '0;
        idx_d   = IDX_TOP;
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (HAS_GAP) begin
            state_d = ST_GAP;
          end else if (idx_q == '0) begin
            state_d = ST_LOAD;
            idx_d   = IDX_TOP;
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = ST_LOAD;
            idx_d   = IDX_TOP;
          end else begin
            state_d = ST_SHOW;
            idx_d   = idx_q - IDXW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
        idx_d   = IDX_TOP;
      end
    endcase
  end

  // Snapshot is only replaced in LOAD; select the digit for the next cycle
  always_comb begin
    snap_d   = (state_q == ST_LOAD) ? raw : snap_q;
    cur_code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDXW'(i)) cur_code = snap_d[i];
    end
  end

  seg7_decode u_dec (
    .code (cur_code),
    .seg  (dec_seg)
  );

  // Output look-ahead: decode from next state so SEG is valid on SHOW entry
  always_comb begin
    seg_d   = (state_d == ST_SHOW) ? dec_seg : SEG_OFF;
    dp_d    = (state_d == ST_SHOW) && (idx_d == '0);
    frame_d = (state_q == ST_LOAD);
  end

  // State, snapshot and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      idx_q   <= IDX_TOP;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign SEG   = seg_q;
  assign DP    = dp_q;
  assign IDX   = idx_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner: per-cycle expected records are queued
// per frame by the stimulus and compared by an independent monitor.
module tb_digit_scanner;

  localparam int DW = 8;
  localparam int GP = 2;
  localparam int FRAME_LEN = 1 + 9 * (DW + GP);

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] idx;
    logic       frame;
  } rec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [8:0][4:0] din;
  logic [8:0][4:0] din2;
  logic [6:0] SEG, SEG2;
  logic       DP, DP2;
  logic [3:0] IDX, IDX2;
  logic       FRAME, FRAME2;

  rec_t exp_q[$];
  logic mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;

  always #5 CLK = ~CLK;

  digit_scanner #(.DWELL(DW), .GAP(GP), .IDXW(4)) dut (
    .CLK(CLK), .RST(RST),
    .HUN_MIL(din[8]), .TEN_MIL(din[7]), .MIL(din[6]),
    .HUN_THOU(din[5]), .TEN_THOU(din[4]), .THOU(din[3]),
    .HUND(din[2]), .TENS(din[1]), .ONES(din[0]),
    .SEG(SEG), .DP(DP), .IDX(IDX), .FRAME(FRAME)
  );

  digit_scanner #(.DWELL(1), .GAP(0), .IDXW(4)) dut2 (
    .CLK(CLK), .RST(RST),
    .HUN_MIL(din2[8]), .TEN_MIL(din2[7]), .MIL(din2[6]),
    .HUN_THOU(din2[5]), .TEN_THOU(din2[4]), .THOU(din2[3]),
    .HUND(din2[2]), .TENS(din2[1]), .ONES(din2[0]),
    .SEG(SEG2), .DP(DP2), .IDX(IDX2), .FRAME(FRAME2)
  );

  // Monitor: one expected record per clock cycle while armed
  always @(negedge CLK) begin
    if (mon_en && exp_q.size() > 0) begin
      rec_t r;
      r = exp_q.pop_front();
      checks++;
      ncyc++;
      if ({SEG, DP, IDX, FRAME} !== r) begin
        failures++;
        $display("FAIL scan cyc=%0d got seg=%h dp=%b idx=%0d frame=%b exp seg=%h dp=%b idx=%0d frame=%b",
                 ncyc, SEG, DP, IDX, FRAME, r.seg, r.dp, r.idx, r.frame);
      end
    end
  end

  task automatic push_frame(input logic [8:0][6:0] gv);
    rec_t r;
    for (int i = 8; i >= 0; i--) begin
      for (int c = 0; c < DW; c++) begin
        r.seg = gv[i]; r.dp = (i == 0); r.idx = 4'(i); r.frame = (i == 8 && c == 0);
        exp_q.push_back(r);
      end
      for (int c = 0; c < GP; c++) begin
        r.seg = 7'h00; r.dp = 1'b0; r.idx = 4'(i); r.frame = 1'b0;
        exp_q.push_back(r);
      end
    end
    r.seg = 7'h00; r.dp = 1'b0; r.idx = 4'd8; r.frame = 1'b0;
    exp_q.push_back(r);
  endtask

  task automatic wait_frame(input int chg_at, input logic [4:0] chg_val);
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge CLK);
      if (k == chg_at) begin
        #1;
        din[0] = chg_val;
      end
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  initial begin
    logic [8:0][6:0] g2;
    rec_t r;
    bit found;

    // Reset with random inputs
    for (int i = 0; i < 9; i++) din[i] = 5'($urandom_range(0, 31));
    din2 = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    repeat (3) @(negedge CLK);
    chk("rst_seg", 16'(SEG), 16'h00);
    chk("rst_dp", 16'(DP), 16'h0);
    chk("rst_idx", 16'(IDX), 16'h8);
    chk("rst_frame", 16'(FRAME), 16'h0);

    // Frame 1: 9..1, release so the first edge loads
    #1;
    din = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    push_frame({7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06});
    RST = 1'b1;
    mon_en = 1'b1;
    wait_frame(-1, 5'd0);

    // Frame 2: ONES=3, changed to 7 mid-frame; snapshot keeps 3
    din = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3};
`ifdef LEADING_ZERO_BLANK_EN
    push_frame({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h4F});
`else
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h4F});
`endif
    wait_frame(20, 5'd7);

    // Frame 3: the changed ONES value appears now
`ifdef LEADING_ZERO_BLANK_EN
    push_frame({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h07});
`else
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h07});
`endif
    wait_frame(-1, 5'd0);

    // Frame 4: blank request and non-decimal code
    din = {5'h10, 5'h0C, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    push_frame({7'h00, 7'h40, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07});
    wait_frame(-1, 5'd0);

    // Frame 5: 000001200
    din = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd0, 5'd0};
`ifdef LEADING_ZERO_BLANK_EN
    push_frame({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h3F, 7'h3F});
`else
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h3F, 7'h3F});
`endif
    wait_frame(-1, 5'd0);

    // Frame 6: all zeros
    din = '0;
`ifdef LEADING_ZERO_BLANK_EN
    push_frame({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F});
`else
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
`endif
    wait_frame(-1, 5'd0);

    // Frame 7: async reset in the middle of the first SHOW
    din = {9{5'd8}};
    push_frame({9{7'h7F}});
    repeat (4) @(negedge CLK);
    #2;
    mon_en = 1'b0;
    exp_q.delete();
    RST = 1'b0;
    #1;
    chk("midrst_seg", 16'(SEG), 16'h00);
    chk("midrst_dp", 16'(DP), 16'h0);
    chk("midrst_idx", 16'(IDX), 16'h8);
    chk("midrst_frame", 16'(FRAME), 16'h0);

    // Frame 8: restart after release
    repeat (2) @(negedge CLK);
    #1;
    din = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F});
    RST = 1'b1;
    mon_en = 1'b1;
    wait_frame(-1, 5'd0);
    chk("drain", 16'(exp_q.size()), 16'h0);

    // DWELL=1, GAP=0 instance: 10-cycle frame, digits back to back
    g2 = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge CLK);
      if (FRAME2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL fast_frame_seen got=0 exp=1");
    end else begin
      for (int k = 0; k <= 10; k++) begin
        if (k > 0) @(negedge CLK);
        if (k < 9) begin
          r.seg = g2[8-k]; r.dp = (k == 8); r.idx = 4'(8 - k); r.frame = (k == 0);
        end else if (k == 9) begin
          r.seg = 7'h00; r.dp = 1'b0; r.idx = 4'd8; r.frame = 1'b0;
        end else begin
          r.seg = g2[8]; r.dp = 1'b0; r.idx = 4'd8; r.frame = 1'b1;
        end
        chk($sformatf("fast_k%0d", k), 16'({SEG2, DP2, IDX2, FRAME2}), 16'(r));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
